// File: rtl/cavlc_scan_pkg.sv
// Shared constants for the CAVLC coefficient scan block.
// Scan state codes, zig-zag table and count width.
`ifndef RES_WIDTH
`define RES_WIDTH 16
`endif

package cavlc_scan_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [3:0] {
    SCAN_INIT   = 4'd0,
    SCAN_CYCLE0 = 4'd1,
    SCAN_CYCLE1 = 4'd2,
    SCAN_CYCLE2 = 4'd3,
    SCAN_CYCLE3 = 4'd4,
    SCAN_CYCLE4 = 4'd5,
    SCAN_CYCLE5 = 4'd6,
    SCAN_CYCLE6 = 4'd7,
    SCAN_CYCLE7 = 4'd8,
    SCAN_DONE   = 4'd9
  } scan_state_e;

  // Zig-zag position p -> raster index, entry p at [p*4 +: 4].
  localparam logic [63:0] ZZ_TBL = {
    4'd15, 4'd14, 4'd11, 4'd7,
    4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5,
    4'd8,  4'd4,  4'd1,  4'd0
  };

  function automatic logic [3:0] zz_raster(
    input logic [3:0] pos
  );
    return ZZ_TBL[pos*4 +: 4];
  endfunction

endpackage

// File: rtl/cavlc_scan_buf.sv
// Coefficient bank with zig-zag pair read mux.
// CAVLC_SCAN_PINGPONG_EN adds a shadow bank with a full flag.
module cavlc_scan_buf
  import cavlc_scan_pkg::*;
#(
  parameter int RES_WIDTH = `RES_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
`ifdef CAVLC_SCAN_PINGPONG_EN
  input  logic                   shd_load,
  input  logic                   xfer,
  output logic                   shd_full,
`endif
  input  logic [16*RES_WIDTH-1:0] blk_coeff,
  input  logic                   rd_en,
  input  logic [2:0]             rd_cyc,
  output logic [RES_WIDTH-1:0]   coeff0,
  output logic [RES_WIDTH-1:0]   coeff1
);

  localparam int BW = 16 * RES_WIDTH;

  logic [BW-1:0] coef_q, coef_d;
  logic [3:0]    idx0, idx1;

`ifdef CAVLC_SCAN_PINGPONG_EN
  logic [BW-1:0] shd_q, shd_d;
  logic          shd_full_q, shd_full_d;

  assign shd_full = shd_full_q;
`endif

  always_comb begin
    coef_d = coef_q;
    if (load) coef_d = blk_coeff;
`ifdef CAVLC_SCAN_PINGPONG_EN
    else if (xfer) coef_d = shd_q;
    shd_d      = shd_q;
    shd_full_d = shd_full_q;
    if (shd_load) begin
      shd_d      = blk_coeff;
      shd_full_d = 1'b1;
    end else if (xfer) begin
      shd_full_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q <= '0;
`ifdef CAVLC_SCAN_PINGPONG_EN
      shd_q      <= '0;
      shd_full_q <= 1'b0;
`endif
    end else begin
      coef_q <= coef_d;
`ifdef CAVLC_SCAN_PINGPONG_EN
      shd_q      <= shd_d;
      shd_full_q <= shd_full_d;
`endif
    end
  end

  // Cycle k reads zig-zag positions 15-2k and 14-2k.
  assign idx0 = zz_raster({~rd_cyc, 1'b1});
  assign idx1 = zz_raster({~rd_cyc, 1'b0});

  always_comb begin
    coeff0 = '0;
    coeff1 = '0;
    if (rd_en) begin
      coeff0 = coef_q[idx0*RES_WIDTH +: RES_WIDTH];
      coeff1 = coef_q[idx1*RES_WIDTH +: RES_WIDTH];
    end
  end

endmodule

// File: rtl/cavlc_coeff_scan.sv
// Zig-zag scan feeder for CAVLC: FSM, nz counter, handshake.
// Optional ping-pong buffering via CAVLC_SCAN_PINGPONG_EN.
module cavlc_coeff_scan
  import cavlc_scan_pkg::*;
#(
  parameter int RES_WIDTH = `RES_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [16*RES_WIDTH-1:0] blk_coeff,
  output logic [RES_WIDTH-1:0]    coeff0,
  output logic [RES_WIDTH-1:0]    coeff1,
  output logic [3:0]              state,
  output logic [CNT_W-1:0]        total_coeff,
  output logic                    scan_done
);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] nz_q, nz_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] nz_inc;

  logic       accept, load, xfer, scan_en;
  logic [2:0] rd_cyc;

`ifdef CAVLC_SCAN_PINGPONG_EN
  logic shd_load, shd_full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SCAN_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN_INIT:   if (accept) state_d = SCAN_CYCLE0;
      SCAN_CYCLE0, SCAN_CYCLE1, SCAN_CYCLE2,
      SCAN_CYCLE3, SCAN_CYCLE4, SCAN_CYCLE5,
      SCAN_CYCLE6: state_d = scan_state_e'(state_q + 4'd1);
      SCAN_CYCLE7: state_d = SCAN_DONE;
      SCAN_DONE:   state_d = xfer ? SCAN_CYCLE0 : SCAN_INIT;
      default:     state_d = SCAN_INIT;
    endcase
  end

  always_comb begin
    scan_en = (state_q >= SCAN_CYCLE0) && (state_q <= SCAN_CYCLE7);
    rd_cyc  = 3'(state_q - 4'd1);
`ifdef CAVLC_SCAN_PINGPONG_EN
    blk_ready = !shd_full && !rst;
`else
    blk_ready = (state_q == SCAN_INIT) && !rst;
`endif
    accept = blk_valid && blk_ready;
    load   = accept && (state_q == SCAN_INIT);
`ifdef CAVLC_SCAN_PINGPONG_EN
    shd_load = accept && (state_q != SCAN_INIT);
    xfer     = (state_q == SCAN_DONE) && shd_full;
`else
    xfer     = 1'b0;
`endif
  end

  cavlc_scan_buf #(
    .RES_WIDTH (RES_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
`ifdef CAVLC_SCAN_PINGPONG_EN
    .shd_load  (shd_load),
    .xfer      (xfer),
    .shd_full  (shd_full),
`endif
    .blk_coeff (blk_coeff),
    .rd_en     (scan_en),
    .rd_cyc    (rd_cyc),
    .coeff0    (coeff0),
    .coeff1    (coeff1)
  );

  assign nz_inc = CNT_W'(coeff0 != '0) + CNT_W'(coeff1 != '0);

  always_comb begin
    nz_d    = nz_q;
    total_d = total_q;
    done_d  = (state_q == SCAN_CYCLE7);
    if (load || xfer) nz_d = '0;
    else if (scan_en) nz_d = nz_q + nz_inc;
    // Final sum includes the pair visible in CYCLE7.
    if (state_q == SCAN_CYCLE7) total_d = nz_q + nz_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q    <= '0;
      total_q <= '0;
      done_q  <= 1'b0;
    end else begin
      nz_q    <= nz_d;
      total_q <= total_d;
      done_q  <= done_d;
    end
  end

  assign state       = state_q;
  assign total_coeff = total_q;
  assign scan_done   = done_q;

endmodule
